fletcher_checksum_verifier: RTL and testbench

//   Receive-side counterpart of the Fletcher checksum generator. Consumes a

---
 rtl/fletcher_pkg.sv | 18 +
 rtl/fletcher_checksum_verifier_accum.sv | 34 +++
 rtl/fletcher_checksum_verifier.sv | 95 +++++++++
 tb/tb_fletcher_checksum_verifier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fletcher_pkg.sv
// fletcher_pkg: shared FSM state type and ones-complement helpers for the Fletcher verifier.
package fletcher_pkg;
  typedef enum logic [2:0] {IDLE, DATA, CKB, CKA, DONE} state_e;
  function automatic logic [63:0] canon(input logic [63:0] x, input int unsigned h);
    logic [63:0] m;
    m = (64'd1 << h) - 64'd1;
    return (x == m) ? 64'd0 : x;
  endfunction
  // Operands are at most M, so a single end-around fold is enough.
  function automatic logic [63:0] ones_add(input logic [63:0] a, input logic [63:0] b, input int unsigned h);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << h) - 64'd1;
    s = a + b;
    s = (s & m) + (s >> h);
    return canon(s, h);
  endfunction
endpackage

// File: rtl/fletcher_checksum_verifier_accum.sv
// fletcher_accum: Fletcher A/B running-sum pair, canonical mod 2^H-1, with clear and enable.
module fletcher_accum
  import fletcher_pkg::*;
#(
  parameter int H = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [H-1:0] din_i,
  output logic [H-1:0] a_o,
  output logic [H-1:0] b_o
);
  logic [H-1:0] a_q, a_d, b_q, b_d;
  logic [63:0]  a_sum, b_sum;
  always_comb begin
    a_sum = ones_add(64'(a_q), 64'(din_i), H);
    b_sum = ones_add(64'(b_q), 64'(a_sum[H-1:0]), H);
    a_d   = clr_i ? '0 : en_i ? a_sum[H-1:0] : a_q;
    b_d   = clr_i ? '0 : en_i ? b_sum[H-1:0] : b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign a_o = a_q;
  assign b_o = b_q;
endmodule

// File: rtl/fletcher_checksum_verifier.sv
// fletcher_checksum_verifier: checks a length-prefixed payload against trailing Fletcher B,A halves.
// Optional error counter port errcnt enabled by `FLETCHER_VERIFIER_ERRCNT_EN.
module fletcher_checksum_verifier
  import fletcher_pkg::*;
#(
  parameter int Width    = 32,
  parameter int LenWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LenWidth-1:0]  len,
  input  logic [Width/2-1:0]   din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 busy,
  output logic                 done,
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
  output logic [7:0]           errcnt,
`endif
  output logic                 ok
);
  localparam int H = Width / 2;
  state_e              state_q, state_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [H-1:0]        rxb_q, rxb_d;
  logic                ok_q, ok_d;
  logic [H-1:0]        acc_a, acc_b;
  logic                xfer, match;
  assign din_ready = (state_q == DATA) || (state_q == CKB) || (state_q == CKA);
  assign xfer      = din_valid && din_ready;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign ok        = ok_q;
  // Received halves are canonicalised so all-ones and zero compare equal.
  assign match = (canon(64'(rxb_q), H) == 64'(acc_b)) && (canon(64'(din), H) == 64'(acc_a));
  fletcher_accum #(.H(H)) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == IDLE && start),
    .en_i  (state_q == DATA && xfer),
    .din_i (din),
    .a_o   (acc_a),
    .b_o   (acc_b)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rxb_d   = rxb_q;
    ok_d    = ok_q;
    case (state_q)
      IDLE: if (start) begin
        rem_d   = len;
        ok_d    = 1'b0;
        state_d = (len != '0) ? DATA : CKB;
      end
      DATA: if (xfer) begin
        rem_d   = rem_q - LenWidth'(1);
        state_d = (rem_q == LenWidth'(1)) ? CKB : DATA;
      end
      CKB: if (xfer) begin
        rxb_d   = din;
        state_d = CKA;
      end
      CKA: if (xfer) begin
        ok_d    = match;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      rxb_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rxb_q   <= rxb_d;
      ok_q    <= ok_d;
    end
  end
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  assign errcnt_d = (done && !ok_q && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errcnt_q <= '0;
    else        errcnt_q <= errcnt_d;
  end
  assign errcnt = errcnt_q;
`endif
endmodule

// File: tb/tb_fletcher_checksum_verifier.sv
// tb_fletcher_checksum_verifier: randomized scoreboard bench against a plain-arithmetic Fletcher-32 model.
module tb_fletcher_checksum_verifier;
  logic        clk = 0, rst_n = 0, start = 0, din_valid = 0;
  logic [15:0] len = 0, din = 0;
  logic        din_ready, busy, done, ok;
  int          n_cmp = 0, n_fail = 0;
  bit          expq[$];
  bit          mon_e;
  logic [15:0] pay[$];
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
  logic [7:0]  errcnt;
  int          exp_err = 0;
`endif

  fletcher_checksum_verifier #(.Width(32), .LenWidth(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
    .errcnt    (errcnt),
`endif
    .ok        (ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: Fletcher-32 by definition, sums modulo 65535.
  function automatic logic [31:0] fl();
    int a = 0, b = 0;
    foreach (pay[i]) begin
      a = (a + int'(pay[i])) % 65535;
      b = (b + a) % 65535;
    end
    return {16'(b), 16'(a)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy && din_ready !== 1'b0) chk("ready_in_idle", din_ready, 0);
      if (done) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no verdict pending");
        end else begin
          mon_e = expq.pop_front();
          chk("ok_verdict", ok, mon_e);
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
          chk("errcnt_before", errcnt, exp_err);
          if (!mon_e && exp_err < 255) exp_err++;
`endif
        end
      end
    end
  end

  task automatic word(input logic [15:0] w, input bit gaps);
    int k = 0;
    bit r = 0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      din_valid = 0;
      din = 16'($urandom);
      @(posedge clk); #1;
    end
    din = w;
    din_valid = 1;
    while (!r && k < 50) begin
      @(negedge clk);
      r = din_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!r) begin
      n_cmp++;
      n_fail++;
      $display("FAIL xfer_timeout: got din_ready=0 for 50 cycles expected 1");
    end
    din_valid = 0;
  endtask

  task automatic pulse_start(input int l);
    start = 1;
    len = 16'(l);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [15:0] rb, input logic [15:0] ra, input bit gaps, input bit midstart);
    logic [31:0] ck;
    ck = fl();
    expq.push_back(((int'(rb) % 65535) == int'(ck[31:16])) && ((int'(ra) % 65535) == int'(ck[15:0])));
    pulse_start(pay.size());
    foreach (pay[i]) begin
      word(pay[i], gaps);
      if (midstart && i == 0) pulse_start(5);
    end
    word(rb, gaps);
    word(ra, gaps);
    chk("done_latency", done, 1);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [31:0] ck;
    logic [15:0] ra;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", ok, 0);
    chk("rst_ready", din_ready, 0);
    rst_n = 1;
    @(posedge clk); #1;

    pay = '{16'h0001, 16'h0002};
    send(16'h0004, 16'h0003, 0, 0);
    send(16'h0005, 16'h0003, 0, 0);
    pay = {};
    send(16'hFFFF, 16'h0000, 0, 0);
    send(16'h0001, 16'h0000, 0, 0);
    pay = '{16'hFFFE, 16'hFFFE, 16'hFFFE};
    send(16'hFFF9, 16'hFFFC, 1, 1);

    // Reset in the middle of a len=4 payload discards the packet.
    pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    pulse_start(4);
    word(16'h1111, 0);
    word(16'h2222, 0);
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ok", ok, 0);
    chk("midrst_ready", din_ready, 0);
`ifdef FLETCHER_VERIFIER_ERRCNT_EN
    exp_err = 0;
    chk("midrst_errcnt", errcnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    pay = '{16'h1234};
    send(16'h1234, 16'h1234, 0, 0);

    for (int n = 0; n < 30; n++) begin
      pay = {};
      for (int i = $urandom_range(1, 64); i > 0; i--) pay.push_back(16'($urandom));
      ck = fl();
      ra = ck[15:0];
      if ($urandom_range(0, 3) == 0) ra = ra ^ 16'(1 << $urandom_range(0, 15));
      send(ck[31:16], ra, $urandom_range(0, 1) == 1, 0);
    end

    for (int k = 0; k < 100 && expq.size() != 0; k++) @(posedge clk);
    if (expq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d verdicts pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
